// File: rtl/dm_arbiter.sv
// dm_arbiter: arbitrates the single-port data memory (DM) between the CPU
// load/store port and the DMA/loader port. One DM access per cycle at most.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request (held until cpu_gnt)
//   cpu_gnt                         combinational grant; access at this edge
//   cpu_rvalid, cpu_rdata           registered read response, 1 cycle after grant
//   dma_req/we/addr/wdata/lock      DMA request; lock asks for burst ownership
//   dma_gnt, dma_rvalid, dma_rdata  DMA grant / read response
//   DM_write, DM_enable             active-low DM controls
//   DM_address, DM_in, DM_out       DM address / write data / read data
//
// Optional feature, macro DM_ARB_STATS_EN:
//   stats_clr (in), cpu_grant_cnt, dma_grant_cnt, starve_cnt (out, CNT_W bits)
//
// FSM states:
//   state    | meaning
//   ST_ARB   | normal arbitration: CPU first unless DMA has waited MAX_WAIT
//   ST_BURST | DMA owns DM for a locked burst, CPU blocked

module dm_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 16
`ifdef DM_ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
`ifdef DM_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cpu_grant_cnt,
    output logic [CNT_W-1:0] dma_grant_cnt,
    output logic [CNT_W-1:0] starve_cnt,
`endif
    output logic        DM_write,
    output logic        DM_enable,
    output logic [15:0] DM_address,
    output logic [31:0] DM_in,
    input  logic [31:0] DM_out
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               force_cpu_q, force_cpu_d;
    logic               cpu_rvalid_q, cpu_rvalid_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               dma_rvalid_q, dma_rvalid_d;
    logic [31:0]        dma_rdata_q, dma_rdata_d;

    logic dma_priority;
    logic cpu_gnt_w;
    logic dma_gnt_w;

    assign dma_priority = (wait_cnt_q == WAIT_W'(MAX_WAIT));

    // Output process: grants and DM controls. Grants are forced low while
    // reset is asserted so DM sees no access during reset.
    always_comb begin
        cpu_gnt_w = 1'b0;
        dma_gnt_w = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_ARB: begin
                    if (force_cpu_q && cpu_req) begin
                        cpu_gnt_w = 1'b1;
                    end else if (cpu_req && !dma_priority) begin
                        cpu_gnt_w = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt_w = 1'b1;
                    end
                end
                ST_BURST: begin
                    dma_gnt_w = dma_req;
                end
                default: begin
                    cpu_gnt_w = 1'b0;
                    dma_gnt_w = 1'b0;
                end
            endcase
        end

        DM_enable  = 1'b1;
        DM_write   = 1'b1;
        DM_address = 16'h0000;
        DM_in      = 32'h0000_0000;
        if (cpu_gnt_w) begin
            DM_enable  = 1'b0;
            DM_write   = ~cpu_we;
            DM_address = cpu_addr;
            DM_in      = cpu_wdata;
        end else if (dma_gnt_w) begin
            DM_enable  = 1'b0;
            DM_write   = ~dma_we;
            DM_address = dma_addr;
            DM_in      = dma_wdata;
        end
    end

    assign cpu_gnt = cpu_gnt_w;
    assign dma_gnt = dma_gnt_w;

    // Next-state process.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        force_cpu_d = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (dma_gnt_w && dma_lock) begin
                    burst_cnt_d = BURST_W'(1);
                    // A one-grant burst is already at its limit.
                    if (BURST_MAX <= 1) begin
                        force_cpu_d = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (dma_gnt_w) begin
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                end
                // Release on the grant that reaches the limit, so the CPU
                // gets the very next cycle with no dead slot.
                if (dma_gnt_w && (burst_cnt_d == BURST_W'(BURST_MAX))) begin
                    state_d     = ST_ARB;
                    force_cpu_d = 1'b1;
                end else if (!dma_req || !dma_lock) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Anti-starvation counter and read response datapath.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (dma_gnt_w) begin
            wait_cnt_d = '0;
        end else if (dma_req && !dma_priority) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        cpu_rvalid_d = cpu_gnt_w && !cpu_we;
        cpu_rdata_d  = cpu_rvalid_d ? DM_out : cpu_rdata_q;
        dma_rvalid_d = dma_gnt_w && !dma_we;
        dma_rdata_d  = dma_rvalid_d ? DM_out : dma_rdata_q;
    end

    // State register process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            wait_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            force_cpu_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 32'h0000_0000;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            force_cpu_q  <= force_cpu_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

`ifdef DM_ARB_STATS_EN
    logic [CNT_W-1:0] cpu_grant_cnt_q, cpu_grant_cnt_d;
    logic [CNT_W-1:0] dma_grant_cnt_q, dma_grant_cnt_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        cpu_grant_cnt_d = cpu_grant_cnt_q + (cpu_gnt_w ? CNT_W'(1) : CNT_W'(0));
        dma_grant_cnt_d = dma_grant_cnt_q + (dma_gnt_w ? CNT_W'(1) : CNT_W'(0));
        starve_cnt_d    = starve_cnt_q + (dma_priority ? CNT_W'(1) : CNT_W'(0));
        if (stats_clr) begin
            cpu_grant_cnt_d = '0;
            dma_grant_cnt_d = '0;
            starve_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_grant_cnt_q <= '0;
            dma_grant_cnt_q <= '0;
            starve_cnt_q    <= '0;
        end else begin
            cpu_grant_cnt_q <= cpu_grant_cnt_d;
            dma_grant_cnt_q <= dma_grant_cnt_d;
            starve_cnt_q    <= starve_cnt_d;
        end
    end

    assign cpu_grant_cnt = cpu_grant_cnt_q;
    assign dma_grant_cnt = dma_grant_cnt_q;
    assign starve_cnt    = starve_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a behavioural single-port DM model.
// Inputs change just after the falling edge; outputs are checked 1 ns later.

module tb_dm_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_lock;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        DM_write, DM_enable;
    logic [15:0] DM_address;
    logic [31:0] DM_in, DM_out;
`ifdef DM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] cpu_grant_cnt, dma_grant_cnt, starve_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:65535];

    dm_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
`ifdef DM_ARB_STATS_EN
        .stats_clr     (stats_clr),
        .cpu_grant_cnt (cpu_grant_cnt),
        .dma_grant_cnt (dma_grant_cnt),
        .starve_cnt    (starve_cnt),
`endif
        .DM_write   (DM_write),
        .DM_enable  (DM_enable),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_out     (DM_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DM: combinational read, write at the rising edge.
    assign DM_out = mem[DM_address];
    always @(posedge clk) begin
        if (!DM_enable && !DM_write) mem[DM_address] <= DM_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_en"},   32'(DM_enable),  32'd1);
        chk({tag, "_wr"},   32'(DM_write),   32'd1);
        chk({tag, "_addr"}, 32'(DM_address), 32'd0);
        chk({tag, "_din"},  DM_in,           32'd0);
        chk({tag, "_cgnt"}, 32'(cpu_gnt),    32'd0);
        chk({tag, "_dgnt"}, 32'(dma_gnt),    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 32'h0;
        dma_lock = 1'b0;
`ifdef DM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // During reset: grants suppressed even with a request present.
        #2;
        check_idle("rst");
        chk("rst_crv", 32'(cpu_rvalid), 32'd0);
        chk("rst_drv", 32'(dma_rvalid), 32'd0);
        chk("rst_crd", cpu_rdata, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        cpu_req = 1'b0;

        // Idle cycle.
        @(negedge clk); #1;
        check_idle("idle");
        chk("idle_crv", 32'(cpu_rvalid), 32'd0);
        chk("idle_drv", 32'(dma_rvalid), 32'd0);

        // CPU write then read back.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("cw_gnt",  32'(cpu_gnt),    32'd1);
        chk("cw_en",   32'(DM_enable),  32'd0);
        chk("cw_wr",   32'(DM_write),   32'd0);
        chk("cw_addr", 32'(DM_address), 32'h10);
        chk("cw_din",  DM_in,           32'hDEADBEEF);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("cw_rv",   32'(cpu_rvalid), 32'd0);
        chk("cr_gnt",  32'(cpu_gnt),    32'd1);
        chk("cr_wr",   32'(DM_write),   32'd1);
        chk("cr_en",   32'(DM_enable),  32'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("cr_rv",   32'(cpu_rvalid), 32'd1);
        chk("cr_rd",   cpu_rdata,       32'hDEADBEEF);
        chk("cr_drv",  32'(dma_rvalid), 32'd0);
        @(negedge clk); #1;
        chk("cr_rv_end", 32'(cpu_rvalid), 32'd0);
        chk("cr_rd_hold", cpu_rdata, 32'hDEADBEEF);

        // Contention: CPU wins 8 cycles, DMA wins the 9th, CPU the 10th.
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'h11112222;
                dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0030; dma_wdata = 32'h33334444;
                dma_lock = 1'b0;
            end
            #1;
            chk($sformatf("cont_cgnt%0d", cyc), 32'(cpu_gnt), (cyc == 8) ? 32'd0 : 32'd1);
            chk($sformatf("cont_dgnt%0d", cyc), 32'(dma_gnt), (cyc == 8) ? 32'd1 : 32'd0);
            chk($sformatf("cont_addr%0d", cyc), 32'(DM_address), (cyc == 8) ? 32'h30 : 32'h20);
        end
        @(negedge clk);
        cpu_req = 1'b0; dma_req = 1'b0;
        #1;
        check_idle("cont_end");

        // Locked DMA burst of 20 writes, CPU requesting from the 2nd cycle.
        begin
            int k;
            k = 0;
            for (int cyc = 0; cyc < 21; cyc++) begin
                @(negedge clk);
                if (cyc == 0) begin
                    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
                end
                if (cyc == 1) begin
                    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 32'h5555AAAA;
                end
                if (cyc == 17) cpu_req = 1'b0;
                dma_addr  = 16'h0100 + 16'(k);
                dma_wdata = 32'hA000_0000 + 32'(k);
                #1;
                chk($sformatf("bst_dgnt%0d", cyc), 32'(dma_gnt), (cyc == 16) ? 32'd0 : 32'd1);
                chk($sformatf("bst_cgnt%0d", cyc), 32'(cpu_gnt), (cyc == 16) ? 32'd1 : 32'd0);
                chk($sformatf("bst_addr%0d", cyc), 32'(DM_address),
                    (cyc == 16) ? 32'h200 : (32'h100 + 32'(k)));
                if (cyc != 16) k++;
            end
        end
        @(negedge clk);
        dma_req = 1'b0; dma_lock = 1'b0;
        #1;
        check_idle("bst_end");
        @(negedge clk); #1;
        check_idle("bst_end2");

        // DMA read of the first burst word, CPU idle.
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0100;
        #1;
        chk("dr_gnt", 32'(dma_gnt),   32'd1);
        chk("dr_wr",  32'(DM_write),  32'd1);
        chk("dr_en",  32'(DM_enable), 32'd0);
        @(negedge clk);
        dma_req = 1'b0;
        #1;
        chk("dr_rv",  32'(dma_rvalid), 32'd1);
        chk("dr_rd",  dma_rdata,       32'hA000_0000);
        chk("dr_crv", 32'(cpu_rvalid), 32'd0);
        @(negedge clk); #1;
        chk("dr_rv_end", 32'(dma_rvalid), 32'd0);

        // CPU read of the last burst word, then reset mid-response.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0113;
        #1;
        chk("rr_gnt", 32'(cpu_gnt), 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("rr_rv", 32'(cpu_rvalid), 32'd1);
        chk("rr_rd", cpu_rdata, 32'hA000_0013);
`ifdef DM_ARB_STATS_EN
        chk("st_cpu", 32'(cpu_grant_cnt), 32'd13);
        chk("st_dma", 32'(dma_grant_cnt), 32'd22);
        chk("st_starve", 32'(starve_cnt), 32'd1);
`endif
        rst_n = 1'b0;
        cpu_req = 1'b1;
        #1;
        chk("mr_rv",  32'(cpu_rvalid), 32'd0);
        chk("mr_rd",  cpu_rdata,       32'd0);
        chk("mr_drd", dma_rdata,       32'd0);
        check_idle("mr");
`ifdef DM_ARB_STATS_EN
        chk("mr_st_cpu", 32'(cpu_grant_cnt), 32'd0);
        chk("mr_st_dma", 32'(dma_grant_cnt), 32'd0);
        chk("mr_st_starve", 32'(starve_cnt), 32'd0);
`endif
        cpu_req = 1'b0;
        #4;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_idle("post_rst");
        chk("post_rst_rv", 32'(cpu_rvalid), 32'd0);

        // The write granted to the CPU during the burst must be in memory.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("fc_rv", 32'(cpu_rvalid), 32'd1);
        chk("fc_rd", cpu_rdata, 32'h5555AAAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (DM) between two requesters: the CPU load/store port and a DMA/loader port.
- Performs at most one DM access per cycle and drives the DM's active-low write/enable controls.
- Returns read data through a registered response one cycle after the grant.
- Uses fixed CPU priority with DMA anti-starvation and an optional locked DMA burst mode.

Parameters:
- MAX_WAIT, 8: cycles a pending DMA request may be denied before it wins priority for one grant.
- BURST_MAX, 16: maximum consecutive DMA grants in locked burst before a forced release.
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; must be held with cpu_we/addr/wdata until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  DM word address.
- cpu_wdata  in  32  write data.
- cpu_gnt  out  1  combinational; the access occurs at this cycle's rising edge.
- cpu_rvalid  out  1  one-cycle pulse, the cycle after a granted read.
- cpu_rdata  out  32  registered read data, valid while cpu_rvalid = 1.
- dma_req, dma_we, dma_addr[15:0], dma_wdata[31:0]  in  same meaning as the cpu_* inputs, for the DMA port.
- dma_lock  in  1  request locked burst ownership.
- dma_gnt, dma_rvalid, dma_rdata[31:0]  out  same meaning as the cpu_* outputs, for the DMA port.
- DM_write  out  1  active-low write strobe to DM.
- DM_enable  out  1  active-low enable to DM.
- DM_address  out  16  to DM.
- DM_in  out  32  write data to DM.
- DM_out  in  32  combinational read data from DM.

Behaviour:
- Reset (async, rst_n = 0): FSM state ARB, wait_cnt = 0, burst_cnt = 0, both rvalid = 0, both rdata = 0.
  - Combinational outputs under reset: DM_enable = 1, DM_write = 1, DM_address = 0, DM_in = 0, both gnt = 0.
- Idle (no grant): DM_enable = 1, DM_write = 1, DM_address = 0, DM_in = 0.
- Granted access:
  - DM_enable = 0.
  - DM_write = ~we of the winner.
  - DM_address and DM_in come from the winner.
  - At most one gnt is high in any cycle.
- Write: commits in DM at the grant edge. No rvalid is produced.
- Read: DM_out is sampled into the winner's rdata at the grant edge. That port's rvalid = 1 for exactly the next cycle. Read latency is 1 cycle from grant.
- rdata holds its value until the next read completes on the same port.
- FSM states:
  - ARB:
    - dma_priority = (wait_cnt == MAX_WAIT).
    - Winner is CPU if cpu_req && !dma_priority; otherwise DMA if dma_req.
    - On a DMA grant with dma_lock = 1: move to BURST, burst_cnt = 1.
  - BURST:
    - dma_gnt = dma_req; the CPU is blocked.
    - burst_cnt increments per DMA grant.
    - Exit to ARB when dma_lock = 0, or dma_req = 0, or burst_cnt == BURST_MAX. On a BURST_MAX exit, set wait_cnt = 0.
    - The cycle after a BURST_MAX exit: if cpu_req = 1, the CPU is granted before any new DMA grant (force_cpu flag, one grant).
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle dma_req = 1 && dma_gnt = 0.
  - Clears on any DMA grant.
  - Holds when dma_req = 0.
- Simultaneous cpu_req and dma_req, no priority override: CPU wins; DMA waits with its request held.
- Reset asserted mid-read: the pending rvalid is cancelled (0), rdata = 0. A write granted before the reset edge is already committed.
- Address range: 16 bits covers all 65536 words, so there is no out-of-range case.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined:
  - Adds outputs cpu_grant_cnt[CNT_W-1:0], dma_grant_cnt[CNT_W-1:0] and starve_cnt[CNT_W-1:0].
  - starve_cnt counts cycles with wait_cnt == MAX_WAIT.
  - All three reset to 0, wrap modulo 2^CNT_W, and are cleared by input stats_clr (1 bit, synchronous, takes precedence over increment).
- Not defined: these ports and logic are absent; arbitration behaviour is identical.

Test Plan:
- Reset then idle, no req -> DM_enable = 1, DM_write = 1, DM_address = 0, both rvalid = 0.
- CPU write addr 0x0010 data 0xDEADBEEF, then CPU read 0x0010 -> cpu_gnt each cycle, DM_write = 0 only on the write, cpu_rvalid one cycle after the read grant with cpu_rdata = 0xDEADBEEF.
- CPU and DMA both request continuously:
  - DMA is denied 8 cycles, then wins on the 9th cycle (wait_cnt = 8).
  - wait_cnt returns to 0 and the CPU is granted the following cycle.
- DMA lock burst of 20 writes to 0x0100–0x0113 with cpu_req held:
  - 16 consecutive dma_gnt, then 1 cpu_gnt.
  - DMA resumes and completes the remaining 4 writes.
- DMA read 0x0100 with cpu_req idle -> dma_rvalid next cycle with the stored value; cpu_rvalid stays 0.
- rst_n pulsed low for half a cycle the cycle after a granted read -> cpu_rvalid = 0 and cpu_rdata = 0 immediately; outputs idle; with DM_ARB_STATS_EN, all counters = 0.
